// File: rtl/term_pkg.sv
// Shared terminal definitions: writer FSM states, ASCII control codes and a
// printable-character test.
package term_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    PUT,
    CLR_LINE
  } state_t;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] SPACE = 8'h20;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_writer_if.sv
// Character-stream and character-buffer write bundle for char_writer; the
// writer is the slave side, the keyboard decoder/arbiter/display the master.
interface char_writer_if;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;
  logic       wr_en;
  logic [11:0] wr_ad;
  logic [7:0] wr_data;
  logic       wr_gnt;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic [4:0] top_row;

  modport slave (
    input  ch_valid, ch_data, wr_gnt,
    output ch_ready, wr_en, wr_ad, wr_data, cursor_col, cursor_row, top_row
  );

  modport master (
    output ch_valid, ch_data, wr_gnt,
    input  ch_ready, wr_en, wr_ad, wr_data, cursor_col, cursor_row, top_row
  );
endinterface

// File: rtl/char_writer.sv
// Text-terminal character writer: turns a keyboard character stream into
// character-buffer writes. Define TERM_SCROLL_EN to scroll at the screen bottom.
module char_writer
  import term_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input logic          clk,
  input logic          reset,
  char_writer_if.slave bus
);

  localparam logic [11:0] LAST_AD  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] COLS_AD  = 12'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  state_t      state;
  logic        ch_ready;
  logic        wr_en;
  logic [11:0] wr_ad;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  top_row;
  logic [4:0]  phys_row;
  logic [11:0] row_base;
  logic        no_adv;

  logic [4:0]  nl_row, nl_top, nl_phys;
  logic [11:0] nl_base;
  logic        nl_clear;
  logic        take_nl;
  logic [11:0] col_ad;

  assign bus.ch_ready   = ch_ready;
  assign bus.wr_en      = wr_en;
  assign bus.wr_ad      = wr_ad;
  assign bus.wr_data    = wr_data;
  assign bus.cursor_col = cursor_col;
  assign bus.cursor_row = cursor_row;
  assign bus.top_row    = top_row;

  // row_base tracks phys_row*COLS so the address needs only an adder
  assign col_ad = row_base + {5'd0, cursor_col};

  // The physical row always advances by one on a newline, in both modes
  always_comb begin
    nl_phys  = (phys_row == LAST_ROW) ? 5'd0  : phys_row + 5'd1;
    nl_base  = (phys_row == LAST_ROW) ? 12'd0 : row_base + COLS_AD;
    nl_row   = cursor_row + 5'd1;
    nl_top   = top_row;
    nl_clear = 1'b0;
    if (cursor_row == LAST_ROW) begin
      nl_clear = 1'b1;
`ifdef TERM_SCROLL_EN
      nl_row = cursor_row;
      nl_top = (top_row == LAST_ROW) ? 5'd0 : top_row + 5'd1;
`else
      nl_row = 5'd0;
      nl_top = 5'd0;
`endif
    end
  end

  assign take_nl = (state == IDLE && bus.ch_valid && bus.ch_data == LF) ||
                   (state == PUT && bus.wr_gnt && !no_adv && cursor_col == LAST_COL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      ch_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_ad      <= 12'd0;
      wr_data    <= SPACE;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
      top_row    <= 5'd0;
      phys_row   <= 5'd0;
      row_base   <= 12'd0;
      no_adv     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (!wr_en) begin
            wr_en <= 1'b1;
          end else if (bus.wr_gnt) begin
            if (wr_ad == LAST_AD) begin
              wr_en    <= 1'b0;
              ch_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              wr_ad <= wr_ad + 12'd1;
            end
          end
        end
        IDLE: begin
          if (bus.ch_valid) begin
            if (is_printable(bus.ch_data)) begin
              wr_en    <= 1'b1;
              wr_ad    <= col_ad;
              wr_data  <= bus.ch_data;
              no_adv   <= 1'b0;
              ch_ready <= 1'b0;
              state    <= PUT;
            end else if (bus.ch_data == CR) begin
              cursor_col <= 7'd0;
            end else if (bus.ch_data == BS && cursor_col != 7'd0) begin
              cursor_col <= cursor_col - 7'd1;
              wr_en      <= 1'b1;
              wr_ad      <= col_ad - 12'd1;
              wr_data    <= SPACE;
              no_adv     <= 1'b1;
              ch_ready   <= 1'b0;
              state      <= PUT;
            end
          end
        end
        PUT: begin
          if (bus.wr_gnt) begin
            wr_en    <= 1'b0;
            ch_ready <= 1'b1;
            state    <= IDLE;
            if (!no_adv) begin
              cursor_col <= (cursor_col == LAST_COL) ? 7'd0 : cursor_col + 7'd1;
            end
          end
        end
        CLR_LINE: begin
          if (bus.wr_gnt) begin
            if (wr_ad == row_base + {5'd0, LAST_COL}) begin
              wr_en    <= 1'b0;
              ch_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              wr_ad <= wr_ad + 12'd1;
            end
          end
        end
        default: state <= CLEAR;
      endcase

      // Placed last so an end-of-screen newline overrides the return to IDLE
      if (take_nl) begin
        cursor_row <= nl_row;
        top_row    <= nl_top;
        phys_row   <= nl_phys;
        row_base   <= nl_base;
        if (nl_clear) begin
          wr_en    <= 1'b1;
          wr_ad    <= nl_base;
          wr_data  <= SPACE;
          ch_ready <= 1'b0;
          state    <= CLR_LINE;
        end
      end
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Bench for char_writer: random grants and characters against a screen-level
// reference model of cursor movement and expected buffer writes.
module tb_char_writer;
  import term_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  char_writer_if bus();

  char_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int gnt_pct = 100;

  logic [11:0] obs_ad[$];
  logic [7:0]  obs_dt[$];
  logic [11:0] exp_ad[$];
  logic [7:0]  exp_dt[$];
  int m_col, m_row, m_top;

  logic        pend;
  logic        prev_rst;
  logic [11:0] h_ad;
  logic [7:0]  h_dt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Grant driver and write monitor; writes complete where wr_en && wr_gnt
  initial begin
    pend = 1'b0;
    prev_rst = 1'b1;
    h_ad = '0;
    h_dt = '0;
    bus.wr_gnt = 1'b0;
    forever begin
      @(negedge clk);
      bus.wr_gnt = ($urandom_range(0, 99) < gnt_pct);
      #1;
      if (pend && !prev_rst && !reset) begin
        chk("hold_en", bus.wr_en, 1);
        chk("hold_ad", bus.wr_ad, h_ad);
        chk("hold_dt", bus.wr_data, h_dt);
      end
      pend = bus.wr_en && !bus.wr_gnt && !reset;
      h_ad = bus.wr_ad;
      h_dt = bus.wr_data;
      if (bus.wr_en && bus.wr_gnt && !reset) begin
        obs_ad.push_back(bus.wr_ad);
        obs_dt.push_back(bus.wr_data);
      end
      prev_rst = reset;
    end
  end

  // Reference model: screen position arithmetic and the writes it implies
  function automatic int addr_of(input int col);
    return ((m_top + m_row) % ROWS) * COLS + col;
  endfunction

  task automatic m_push(input int a, input logic [7:0] d);
    exp_ad.push_back(12'(a));
    exp_dt.push_back(d);
  endtask

  task automatic m_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
`ifdef TERM_SCROLL_EN
      m_top = (m_top + 1) % ROWS;
`else
      m_row = 0;
      m_top = 0;
`endif
      for (int k = 0; k < COLS; k++) m_push(addr_of(k), SPACE);
    end
  endtask

  task automatic m_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_push(addr_of(m_col), c);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_newline();
      end
    end else if (c == CR) begin
      m_col = 0;
    end else if (c == LF) begin
      m_newline();
    end else if (c == BS && m_col > 0) begin
      m_col--;
      m_push(addr_of(m_col), SPACE);
    end
  endtask

  task automatic m_reset();
    m_col = 0;
    m_row = 0;
    m_top = 0;
    exp_ad.delete();
    exp_dt.delete();
    for (int a = 0; a < COLS * ROWS; a++) m_push(a, SPACE);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.ch_ready && !bus.wr_en) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    bus.ch_data  = c;
    bus.ch_valid = 1'b1;
    while (!bus.ch_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("accept_timeout", 0, 1);
    @(negedge clk);
    bus.ch_valid = 1'b0;
  endtask

  task automatic compare();
    int n;
    chk("n_writes", obs_ad.size(), exp_ad.size());
    n = (obs_ad.size() < exp_ad.size()) ? obs_ad.size() : exp_ad.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_ad", obs_ad[i], exp_ad[i]);
      chk("wr_data", obs_dt[i], exp_dt[i]);
    end
    obs_ad.delete();
    obs_dt.delete();
    exp_ad.delete();
    exp_dt.delete();
    chk("cursor_col", bus.cursor_col, m_col);
    chk("cursor_row", bus.cursor_row, m_row);
    chk("top_row", bus.top_row, m_top);
  endtask

  task automatic put(input logic [7:0] c);
    m_char(c);
    send(c);
    wait_idle();
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    obs_ad.delete();
    obs_dt.delete();
    reset = 1'b0;
    m_reset();
    wait_idle();
    compare();
    chk("ready_after_clear", bus.ch_ready, 1);
  endtask

  initial begin
    logic [7:0] c;
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_ad", bus.wr_ad, 0);
    chk("rst_wr_data", bus.wr_data, 8'h20);
    chk("rst_ch_ready", bus.ch_ready, 0);
    chk("rst_col", bus.cursor_col, 0);
    chk("rst_row", bus.cursor_row, 0);
    chk("rst_top", bus.top_row, 0);
    obs_ad.delete();
    obs_dt.delete();
    reset = 1'b0;
    m_reset();
    wait_idle();
    compare();
    chk("ready_after_clear", bus.ch_ready, 1);

    // 'A' then 'B' held against a withheld grant
    put(8'h41);
    gnt_pct = 0;
    m_char(8'h42);
    send(8'h42);
    repeat (5) begin
      @(negedge clk);
      chk("stall_wr_en", bus.wr_en, 1);
      chk("stall_wr_ad", bus.wr_ad, 1);
      chk("stall_wr_data", bus.wr_data, 8'h42);
    end
    gnt_pct = 100;
    wait_idle();
    compare();
    chk("col_after_B", bus.cursor_col, 2);

    // A full row wraps to the next line
    put(CR);
    for (int i = 0; i < COLS; i++) put(8'($urandom_range(32, 126)));
    chk("wrap_row", bus.cursor_row, 1);

    // Backspace mid-row and at column 0
    put(8'h78);
    put(8'h79);
    put(8'h7A);
    put(BS);
    put(CR);
    put(BS);

    // Random characters and grants
    gnt_pct = 60;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        6:       c = CR;
        7:       c = LF;
        8:       c = BS;
        9:       c = 8'($urandom_range(128, 255));
        default: c = 8'($urandom_range(32, 126));
      endcase
      put(c);
    end

    // Newlines from the top of a fresh screen to past the bottom
    gnt_pct = 100;
    do_reset();
    for (int i = 0; i < ROWS; i++) begin
      m_char(LF);
      send(LF);
      wait_idle();
    end
    compare();
`ifdef TERM_SCROLL_EN
    chk("lf_top", bus.top_row, 1);
    chk("lf_row", bus.cursor_row, ROWS - 1);
`else
    chk("lf_top", bus.top_row, 0);
    chk("lf_row", bus.cursor_row, 0);
`endif

    // Reset in the middle of a line clear
    gnt_pct = 50;
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) put(LF);
    send(LF);
    repeat (3) @(negedge clk);
    chk("in_clr_line", bus.wr_en, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_wr_ad", bus.wr_ad, 0);
    chk("abort_ready", bus.ch_ready, 0);
    obs_ad.delete();
    obs_dt.delete();
    reset = 1'b0;
    m_reset();
    gnt_pct = 100;
    wait_idle();
    compare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_writer.md
CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 SHALL take parameter COLS, default 80, meaning characters per text row.
REQ-002 SHALL take parameter ROWS, default 30, meaning text rows per screen; COLS*ROWS <= 4096.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: clk in, reset in.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ch_valid  input  1  the upstream keyboard decoder offers a character.
REQ-007 SHALL have port ch_data  input  8  ASCII code.
REQ-008 SHALL have port ch_ready  output  1  the character is accepted when ch_valid && ch_ready.
REQ-009 SHALL have port wr_en  output  1  write request to the character buffer.
REQ-010 SHALL have port wr_ad  output  12  character buffer address.
REQ-011 SHALL have port wr_data  output  8  character buffer write data.
REQ-012 SHALL have port wr_gnt  input  1  the arbiter accepts the write this cycle.
REQ-013 SHALL have ports cursor_col  output  7, cursor_row  output  5 and top_row  output  5 (display scroll offset).

Function
REQ-014 SHALL use FSM states CLEAR, IDLE, PUT and CLR_LINE.
REQ-015 SHALL assert ch_ready only in IDLE.
REQ-016 SHALL compute address wr_ad = ((top_row+cursor_row) mod ROWS)*COLS + col, zero-extended to 12 bits.
REQ-017 SHALL hold wr_en, wr_ad and wr_data stable until wr_gnt is seen; the write completes in the cycle where wr_en && wr_gnt.
REQ-018 SHALL raise wr_en on the cycle after a printable character (0x20-0x7E) is accepted, with state PUT and wr_data = ch_data.
REQ-019 SHALL, on grant in PUT, increment cursor_col; at col COLS-1 set col 0 and perform a newline (REQ-022).
REQ-020 SHALL treat 0x0D (CR) as cursor_col <= 0 with no write, returning next cycle.
REQ-021 SHALL treat 0x08 (BS) with col>0 as col <= col-1, then write 0x20 at the new position via PUT without advancing; at col 0 it is a no-op.
REQ-022 SHALL treat 0x0A (LF) or a column wrap as a newline: if row < ROWS-1 then row+1; otherwise apply the end-of-screen rule (Configuration).
REQ-023 SHALL accept and silently drop all other codes.
REQ-024 SHALL, in CLR_LINE, write 0x20 to COLS consecutive addresses of the target physical row, one per grant, then go to IDLE.
REQ-025 SHALL keep top_row, cursor_row and cursor_col as modulo counters that never reach ROWS or COLS.

Reset
REQ-026 SHALL, on reset, set cursor_col=0, cursor_row=0, top_row=0, wr_en=0, wr_ad=0, wr_data=0x20 and ch_ready=0, with state CLEAR.
REQ-027 SHALL, in CLEAR, write 0x20 to addresses 0..COLS*ROWS-1 in order, one per grant, then go to IDLE.
REQ-028 SHALL, on reset asserted mid-operation, abandon any pending write immediately and restart CLEAR.

Configuration
REQ-029 SHALL, with macro TERM_SCROLL_EN defined, handle a newline on row ROWS-1 as top_row <= (top_row+1) mod ROWS with cursor_row unchanged, then CLR_LINE on the new bottom physical row.
REQ-030 SHALL, without TERM_SCROLL_EN, handle a newline on row ROWS-1 as cursor_row <= 0 with top_row held at 0, then CLR_LINE on row 0.

Structure
REQ-031 SHALL place the state enum and the ASCII constants (CR, LF, BS, SPACE) in the shared package term_pkg.
REQ-032 SHALL be a single module with no sub-modules; the address multiply SHALL be an incrementally maintained row base, not a multiplier.

Verification
REQ-033 SHALL cover: reset with wr_gnt=1 -> 2400 writes of 0x20 to addresses 0..2399, then ch_ready=1.
REQ-034 SHALL cover: 'A'(0x41) at (0,0), then 'B' with wr_gnt low for 5 cycles -> wr_ad=1 and wr_data=0x42 held stable, with cursor_col=2 after grant.
REQ-035 SHALL cover: 80 printable characters on row 0 -> cursor_col=0 and cursor_row=1.
REQ-036 SHALL cover: BS at col 3 -> write 0x20 at address 2 and cursor_col=2; BS at col 0 -> no write.
REQ-037 SHALL cover: 30 LFs with TERM_SCROLL_EN -> top_row=1, cursor_row=29 and 80 writes of 0x20 to addresses 0..79; without the macro -> cursor_row=0 and top_row=0.
REQ-038 SHALL cover: reset during CLR_LINE -> wr_en drops the next cycle and CLEAR restarts at address 0.
